s3_twiddle_combiner: RTL and testbench

//  Consumer of the stage-3 twiddle partial products in the 8-point SDF FFT datapath.

---
 rtl/s3_twiddle_combiner.sv | 145 ++++++++++++++
 tb/tb_s3_twiddle_combiner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s3_twiddle_combiner.sv
`default_nettype none
// ============================================================================
//  Module   : s3_twiddle_combiner
//  Purpose  : Stage-3 twiddle combiner of the 8-point SDF FFT datapath.
//             Forms (ac-bd) + j(ad+bc) from four s2.24 partial products,
//             rounds half-up by FRAC_SHIFT bits and saturates to s0.13.
//             Also tags frame boundaries and counts saturated samples.
//             Fixed 2-cycle pipeline, one sample per cycle, no backpressure.
//  Ports    : clk, rst_n (async, active low)
//             in_valid, in_stage, in_rr/in_ii/in_ri/in_ir (partial products)
//             sat_clr (synchronous clear of sat_count)
//             out_valid, out_real, out_imag, out_stage, out_sat, out_last,
//             sat_count
//  Revision : 1.0  initial release
// ============================================================================
module s3_twiddle_combiner #(
    parameter int IN_W       = 27,
    parameter int OUT_W      = 14,
    parameter int FRAC_SHIFT = 11,
    parameter int FRAME_LEN  = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_stage,
    input  logic [IN_W-1:0]  in_rr,
    input  logic [IN_W-1:0]  in_ii,
    input  logic [IN_W-1:0]  in_ri,
    input  logic [IN_W-1:0]  in_ir,
    input  logic             sat_clr,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_real,
    output logic [OUT_W-1:0] out_imag,
    output logic             out_stage,
    output logic             out_sat,
    output logic             out_last,
    output logic [CNT_W-1:0] sat_count
);

    localparam int c_SUM_W = IN_W + 1;   // a difference/sum of two IN_W values never overflows
    localparam int c_RND_W = IN_W + 2;   // rounding add is done one bit wider still
    localparam int c_IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic signed [c_RND_W-1:0] c_HALF = c_RND_W'(2 ** (FRAC_SHIFT - 1));
    localparam logic signed [c_RND_W-1:0] c_MAX  = c_RND_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [c_RND_W-1:0] c_MIN  = c_RND_W'(-(2 ** (OUT_W - 1)));
    localparam logic [c_IDX_W-1:0]        c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]          c_CNT_MAX  = '1;

    // ---------------- stage 1 ----------------
    logic                      r_v1;
    logic                      r_stage1;
    logic signed [c_SUM_W-1:0] r_sum_re;
    logic signed [c_SUM_W-1:0] r_sum_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_stage1 <= 1'b0;
            r_sum_re <= '0;
            r_sum_im <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_stage1 <= in_stage;
                r_sum_re <= $signed({in_rr[IN_W-1], in_rr}) - $signed({in_ii[IN_W-1], in_ii});
                r_sum_im <= $signed({in_ri[IN_W-1], in_ri}) + $signed({in_ir[IN_W-1], in_ir});
            end
        end
    end

    // ---------------- stage 2: round half-up, then clip ----------------
    logic signed [c_RND_W-1:0] w_rnd_re;
    logic signed [c_RND_W-1:0] w_rnd_im;
    logic signed [c_RND_W-1:0] w_sh_re;
    logic signed [c_RND_W-1:0] w_sh_im;
    logic                      w_hi_re, w_lo_re, w_hi_im, w_lo_im;
    logic [OUT_W-1:0]          w_out_re;
    logic [OUT_W-1:0]          w_out_im;
    logic                      w_sat;

    always_comb begin
        w_rnd_re = $signed({r_sum_re[c_SUM_W-1], r_sum_re}) + c_HALF;
        w_rnd_im = $signed({r_sum_im[c_SUM_W-1], r_sum_im}) + c_HALF;
        w_sh_re  = w_rnd_re >>> FRAC_SHIFT;
        w_sh_im  = w_rnd_im >>> FRAC_SHIFT;
        w_hi_re  = (w_sh_re > c_MAX);
        w_lo_re  = (w_sh_re < c_MIN);
        w_hi_im  = (w_sh_im > c_MAX);
        w_lo_im  = (w_sh_im < c_MIN);
        w_out_re = w_hi_re ? c_MAX[OUT_W-1:0] : (w_lo_re ? c_MIN[OUT_W-1:0] : w_sh_re[OUT_W-1:0]);
        w_out_im = w_hi_im ? c_MAX[OUT_W-1:0] : (w_lo_im ? c_MIN[OUT_W-1:0] : w_sh_im[OUT_W-1:0]);
        w_sat    = w_hi_re | w_lo_re | w_hi_im | w_lo_im;
    end

    logic                r_valid;
    logic [OUT_W-1:0]    r_real;
    logic [OUT_W-1:0]    r_imag;
    logic                r_stage;
    logic                r_sat;
    logic                r_last;
    logic [c_IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]    r_cnt;

    // The frame index and saturation counter advance together with the
    // sample being registered, so out_last and sat_count line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_real  <= '0;
            r_imag  <= '0;
            r_stage <= 1'b0;
            r_sat   <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= r_v1;
            r_last  <= r_v1 && (r_idx == c_LAST_IDX);
            if (r_v1) begin
                r_real  <= w_out_re;
                r_imag  <= w_out_im;
                r_stage <= r_stage1;
                r_sat   <= w_sat;
                r_idx   <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (sat_clr) begin
                r_cnt <= '0;
            end else if (r_v1 && w_sat && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_real  = r_real;
    assign out_imag  = r_imag;
    assign out_stage = r_stage;
    assign out_sat   = r_sat;
    assign out_last  = r_last;
    assign sat_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s3_twiddle_combiner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s3_twiddle_combiner
//  Purpose  : Self-checking bench for s3_twiddle_combiner. Table vectors and
//             model-generated vectors feed a scoreboard queue; outputs are
//             popped and compared when out_valid rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_s3_twiddle_combiner;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_stage = 1'b0;
    logic signed [26:0] in_rr = '0, in_ii = '0, in_ri = '0, in_ir = '0;
    logic               sat_clr = 1'b0;
    logic               out_valid;
    logic signed [13:0] out_real, out_imag;
    logic               out_stage, out_sat, out_last;
    logic [7:0]         sat_count;

    s3_twiddle_combiner dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stage(in_stage),
        .in_rr(in_rr), .in_ii(in_ii), .in_ri(in_ri), .in_ir(in_ir),
        .sat_clr(sat_clr), .out_valid(out_valid), .out_real(out_real),
        .out_imag(out_imag), .out_stage(out_stage), .out_sat(out_sat),
        .out_last(out_last), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic stage;
        int   rr, ii, ri, ir;
        int   exp_re, exp_im;
        logic exp_sat;
    } vec_t;

    typedef struct {
        int   due;
        logic stage;
        int   re, im;
        logic sat, last;
        int   cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_idx = 0;
    int   m_cnt = 0;
    exp_t h;        // last emitted expectation: what held outputs must show

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic stage, input int re, input int im, input logic sat);
        exp_t e;
        e.due   = cyc + 2;
        e.stage = stage;
        e.re    = re;
        e.im    = im;
        e.sat   = sat;
        e.last  = (m_idx == 7);
        m_idx   = (m_idx + 1) % 8;
        if (sat && m_cnt < 255) m_cnt++;
        e.cnt   = m_cnt;
        sbq.push_back(e);
    endtask

    function automatic int rnd_clip(input longint s, output logic sat);
        longint r;
        r   = (s + 1024) >>> 11;
        sat = 1'b0;
        if (r > 8191)  begin r = 8191;  sat = 1'b1; end
        if (r < -8192) begin r = -8192; sat = 1'b1; end
        return int'(r);
    endfunction

    task automatic set_in(input logic stage, input int rr, input int ii, input int ri, input int ir);
        in_valid = 1'b1;
        in_stage = stage;
        in_rr = 27'(rr); in_ii = 27'(ii); in_ri = 27'(ri); in_ir = 27'(ir);
    endtask

    task automatic drive_tab(input vec_t v);
        set_in(v.stage, v.rr, v.ii, v.ri, v.ir);
        push_exp(v.stage, v.exp_re, v.exp_im, v.exp_sat);
    endtask

    task automatic drive_model(input logic stage, input int rr, input int ii, input int ri, input int ir);
        int   re, im;
        logic sr, si;
        re = rnd_clip(longint'(rr) - longint'(ii), sr);
        im = rnd_clip(longint'(ri) + longint'(ir), si);
        set_in(stage, rr, ii, ri, ir);
        push_exp(stage, re, im, sr | si);
    endtask

    // Invalid cycle carrying junk data, which must never reach the outputs.
    task automatic bubble();
        in_valid = 1'b0;
        in_stage = 1'($urandom);
        in_rr = 27'($urandom); in_ii = 27'($urandom);
        in_ri = 27'($urandom); in_ir = 27'($urandom);
    endtask

    task automatic check_out();
        exp_t e;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("latency",   cyc, e.due);
                chk("out_real",  out_real, e.re);
                chk("out_imag",  out_imag, e.im);
                chk("out_sat",   out_sat, e.sat);
                chk("out_stage", out_stage, e.stage);
                chk("out_last",  out_last, e.last);
                chk("sat_count", sat_count, e.cnt);
                h = e;
            end
        end else begin
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                chk("missing_valid", 0, 1);
            end
            chk("hold_real",  out_real, h.re);
            chk("hold_imag",  out_imag, h.im);
            chk("hold_sat",   out_sat, h.sat);
            chk("hold_stage", out_stage, h.stage);
            chk("bubble_last", out_last, 0);
            chk("hold_count", sat_count, h.cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_out();
    endtask

    task automatic drain();
        bubble();
        repeat (3) step();
    endtask

    // Asserted between clock edges so a 0 one ns later proves it is asynchronous.
    task automatic do_reset();
        bubble();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_real",  out_real, 0);
        chk("rst_imag",  out_imag, 0);
        chk("rst_stage", out_stage, 0);
        chk("rst_sat",   out_sat, 0);
        chk("rst_last",  out_last, 0);
        chk("rst_count", sat_count, 0);
        sbq.delete();
        m_idx = 0;
        m_cnt = 0;
        h = '{due: 0, stage: 1'b0, re: 0, im: 0, sat: 1'b0, last: 1'b0, cnt: 0};
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab[6];
        exp_t e;
        tab[0] = '{1'b1, 5931008, 0, -5935104, 0, 2896, -2898, 1'b0};
        tab[1] = '{1'b1, 1024, 0, 0, 0, 1, 0, 1'b0};
        tab[2] = '{1'b1, -1024, 0, 0, 0, 0, 0, 1'b0};
        tab[3] = '{1'b1, -1025, 0, 0, 0, -1, 0, 1'b0};
        tab[4] = '{1'b1, 0, 0, -11868759, -11868759, 0, -8192, 1'b1};
        tab[5] = '{1'b0, 8191 * 2048, 0, 0, -8192 * 2048, 8191, -8192, 1'b0};

        h = '{due: 0, stage: 1'b0, re: 0, im: 0, sat: 1'b0, last: 1'b0, cnt: 0};
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Spec vectors back-to-back, then with bubbles between them.
        foreach (tab[i]) begin drive_tab(tab[i]); step(); end
        drain();
        foreach (tab[i]) begin drive_tab(tab[i]); step(); bubble(); step(); end
        drain();

        // Random products, random bubbles, random stage tags.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) bubble();
            else drive_model(1'($urandom), int'($urandom) >>> 6, int'($urandom) >>> 6,
                             int'($urandom) >>> 6, int'($urandom) >>> 6);
            step();
        end
        drain();

        // Framing: 8 valid with 2 bubbles, then 16 back-to-back.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 6) bubble();
            else drive_model(1'b1, i * 4096, 0, 0, i * 2048);
            step();
        end
        for (int i = 0; i < 16; i++) begin drive_model(1'b1, i * 1000, 7, -i, 3); step(); end
        drain();

        // Saturation count: climbs to 255 and holds there.
        do_reset();
        for (int i = 0; i < 300; i++) begin drive_model(1'b1, 0, 0, -11868759, -11868759); step(); end
        drain();
        chk("sat_count_cap", sat_count, 255);
        // Clear coinciding with a saturating sample reaching the output wins.
        drive_model(1'b1, 40000000, -40000000, 0, 0);
        e = sbq.pop_back();
        e.cnt = 0;
        sbq.push_back(e);
        m_cnt = 0;
        step();
        bubble();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        drive_model(1'b1, 40000000, 0, 0, 0);
        step();
        drain();

        // Reset mid-frame after 3 valid outputs, then a fresh frame.
        do_reset();
        for (int i = 0; i < 3; i++) begin drive_model(1'b1, 2048 * (i + 1), 0, 0, 0); step(); end
        drive_model(1'b1, 99 * 2048, 0, 0, 0);
        step();
        chk("pre_reset_outputs", (sbq.size() >= 1) ? 1 : 0, 1);
        do_reset();
        for (int i = 0; i < 9; i++) begin drive_model(1'b0, i * 2048, 0, 0, -i * 2048); step(); end
        drain();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
